exc_irq_ctrl: RTL and testbench
===============================

Name: exc_irq_ctrl

Overview:
- Exception/interrupt sequencer for the single-cycle MIPS core. It decides, once per retired instruction, whether the PC steers to the normal next-PC or to a trap vector.
- Latches peripheral interrupt events and masks them, then arbitrates them against illegal-opcode traps by fixed priority.
- Generates the trap-take strobe, vector, cause code and per-source acknowledge. Tracks in-service state until exception return.
- Clocked by the CPU instruction clock; sits between Control/Peripheral and the PC_next mux.

Parameters:
- N_IRQ, 3, number of interrupt sources. Bit 0 = timer, bit 1 = UART TX, bit 2 = UART RX.
- VEC_BASE, 32'h8000_0000, trap vector base; vector = VEC_BASE + 4*cause.
- MASK_RST, 3'b111, reset value of the mask register.

Ports:
- clk  in  1  CPU instruction clock.
- reset  in  1  reset, asynchronous, active-high.
- irq_src  in  N_IRQ  raw interrupt levels from peripherals; an event is a 0->1 transition.
- monin  in  1  kernel-mode flag (PC[31]); 1 = supervisor, no traps taken.
- illop  in  1  decoder flags the current instruction as illegal.
- step_en  in  1  current instruction retires this cycle; tie to 1 for the single-cycle core.
- eret  in  1  current instruction is exception return (jr $26 in kernel).
- cfg_wr  in  1  write the mask register.
- cfg_wdata  in  N_IRQ  new mask value.
- take  out  1  combinational; redirect PC to vector this cycle and write EPC to $26.
- vector  out  32  trap target address.
- cause  out  3  0 = none, 1 = ILLOP, 2+i = irq_src[i].
- irq_ack  out  N_IRQ  registered one-hot pulse, one cycle, to the serviced peripheral.
- in_service  out  1  registered, 1 while in SERVICE.
- mask  out  N_IRQ  current mask register.
- kerr  out  1  sticky flag: illop seen while monin = 1.

Behaviour:
- Reset (async) values:
  - state = RUN; src_q = 0; pending = 0; mask = MASK_RST.
  - irq_ack = 0; in_service = 0; kerr = 0.
  - take = 0, cause = 0, vector = VEC_BASE (follow from the reset state and inputs).
- Edge detect: src_q <= irq_src each clock; rise = irq_src & ~src_q. pending[i] sets on the clock after rise[i].
- pending[i] clears on the edge where irq_ack[i] asserts. If set and clear coincide, set wins and the bit stays pending.
- Eligible = pending & mask.
- Priority: ILLOP > lowest-index eligible IRQ.
- take = (state == RUN) & ~monin & step_en & (illop | |eligible). Purely combinational from registered state plus inputs, so zero-latency PC steering.
- cause and vector reflect the winning source whenever take = 1. When take = 0, cause = 0.
- States:
  - RUN:
    - On a clock edge with take = 1: go to SERVICE.
    - If the winner is IRQ i: irq_ack[i] = 1 for the next cycle and pending[i] clears.
    - If the winner is ILLOP: no ack.
  - SERVICE:
    - take is held at 0; pending continues to accumulate.
    - On an edge with eret & step_en: go to RUN. A trap may then be taken the following cycle.
  - eret while in RUN is ignored.
- ILLOP while monin = 1: no trap; kerr sets and holds until reset.
- Mask:
  - On cfg_wr, mask <= cfg_wdata at the clock edge.
  - A take in the same cycle uses the old mask.
  - Masking never clears pending; unmasking later lets the held event fire.
- Reset mid-SERVICE or mid-ack pulse: everything returns to reset values and all pending events are lost.
- Widths: vector = VEC_BASE + {cause, 2'b00}, zero-extended to 32 bits, with no carry into bit 31 for the given base.

Decomposition:
- Shared package holds:
  - cause codes CAUSE_NONE/ILLOP/TIMER/UTX/URX;
  - state encoding RUN/SERVICE;
  - VEC_BASE default.
- One sub-module, irq_prio_enc: N_IRQ-wide lowest-index-first priority encoder producing a valid flag plus index. Everything else lives in exc_irq_ctrl.

Test Plan:
- Reset, then pulse irq_src = 3'b001 for 1 cycle with monin = 0:
  - next cycle: take = 1, cause = 2, vector = 8000_0008;
  - the following cycle: irq_ack = 001, in_service = 1.
- Raise irq_src = 3'b110 together in RUN:
  - UART TX wins: cause = 3, vector = 8000_000C;
  - after eret: next take has cause = 4, vector = 8000_0010.
- illop = 1 with irq pending, monin = 0: cause = 1, vector = 8000_0004, irq_ack = 0, pending retained.
- monin = 1 with illop = 1 and pending IRQ: take = 0; kerr = 1 next cycle; take fires once monin = 0.
- cfg_wr mask = 000, then pulse irq_src[0]: take stays 0. Write mask = 001: take = 1 on the cycle after the write.
- Assert reset while in_service = 1 with pending = 3'b100: in_service = 0, pending = 0, mask = 111 immediately, and no take afterward.

Source files
------------

// File: rtl/exc_irq_ctrl_pkg.sv
// Shared definitions for the exception/interrupt sequencer: cause codes,
// sequencer states and the trap vector helper.
package exc_irq_ctrl_pkg;

    localparam int unsigned CAUSE_W      = 3;
    localparam logic [31:0] VEC_BASE_DEF = 32'h8000_0000;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_NONE  = 3'd0,
        CAUSE_ILLOP = 3'd1,
        CAUSE_TIMER = 3'd2,
        CAUSE_UTX   = 3'd3,
        CAUSE_URX   = 3'd4
    } cause_e;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_SERVICE = 1'b1
    } state_e;

    // Each cause owns one word slot above the vector base.
    function automatic logic [31:0] trap_vector(input logic [31:0] base,
                                                input logic [CAUSE_W-1:0] c);
        return base + 32'({c, 2'b00});
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: valid flag plus index of the winner.
module irq_prio_enc #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest set bit is written last.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/exc_irq_ctrl.sv
// Exception/interrupt sequencer: latches IRQ edges, arbitrates against illegal
// opcodes and steers the PC to a trap vector with zero latency.
module exc_irq_ctrl
    import exc_irq_ctrl_pkg::*;
#(
    parameter int unsigned       N_IRQ    = 3,
    parameter logic [31:0]       VEC_BASE = VEC_BASE_DEF,
    parameter logic [N_IRQ-1:0]  MASK_RST = {N_IRQ{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_IRQ-1:0]   irq_src,
    input  logic               monin,
    input  logic               illop,
    input  logic               step_en,
    input  logic               eret,
    input  logic               cfg_wr,
    input  logic [N_IRQ-1:0]   cfg_wdata,
    output logic               take,
    output logic [31:0]        vector,
    output logic [CAUSE_W-1:0] cause,
    output logic [N_IRQ-1:0]   irq_ack,
    output logic               in_service,
    output logic [N_IRQ-1:0]   mask,
    output logic               kerr
);

    localparam int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    state_e             state;
    logic [N_IRQ-1:0]   src_q;
    logic [N_IRQ-1:0]   pending;
    logic [N_IRQ-1:0]   rise;
    logic [N_IRQ-1:0]   eligible;
    logic [N_IRQ-1:0]   ack_set;
    logic               irq_valid;
    logic [IDX_W-1:0]   irq_idx;

    assign rise     = irq_src & ~src_q;
    assign eligible = pending & mask;

    irq_prio_enc #(
        .N     (N_IRQ),
        .IDX_W (IDX_W)
    ) u_prio (
        .req   (eligible),
        .valid (irq_valid),
        .idx   (irq_idx)
    );

    // Trap decision; illegal opcode outranks every interrupt.
    always_comb begin
        take    = 1'b0;
        cause   = CAUSE_NONE;
        ack_set = '0;
        if ((state == ST_RUN) && !monin && step_en && (illop || irq_valid)) begin
            take = 1'b1;
            if (illop) begin
                cause = CAUSE_ILLOP;
            end else begin
                cause            = CAUSE_W'(CAUSE_TIMER) + CAUSE_W'(irq_idx);
                ack_set[irq_idx] = 1'b1;
            end
        end
        vector = trap_vector(VEC_BASE, cause);
    end

    // Sequencer state, pending latch and registered side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            src_q      <= '0;
            pending    <= '0;
            mask       <= MASK_RST;
            irq_ack    <= '0;
            in_service <= 1'b0;
            kerr       <= 1'b0;
        end else begin
            src_q   <= irq_src;
            pending <= (pending & ~ack_set) | rise;
            irq_ack <= ack_set;
            if (cfg_wr) begin
                mask <= cfg_wdata;
            end
            if (illop && monin) begin
                kerr <= 1'b1;
            end
            case (state)
                ST_RUN: begin
                    if (take) begin
                        state      <= ST_SERVICE;
                        in_service <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (eret && step_en) begin
                        state      <= ST_RUN;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_RUN;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Directed bench for exc_irq_ctrl: a rule-level model is compared every cycle,
// plus literal expectations taken from hand-worked scenarios.
module tb_exc_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  irq_src;
    logic        monin, illop, step_en, eret, cfg_wr;
    logic [2:0]  cfg_wdata;
    logic        take;
    logic [31:0] vector;
    logic [2:0]  cause;
    logic [2:0]  irq_ack;
    logic        in_service;
    logic [2:0]  mask;
    logic        kerr;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state, kept as plain per-source flags.
    bit m_pend [3];
    bit m_mask [3];
    bit m_prev [3];
    int m_ack_src;
    bit m_svc;
    bit m_kerr;

    exc_irq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .monin      (monin),
        .illop      (illop),
        .step_en    (step_en),
        .eret       (eret),
        .cfg_wr     (cfg_wr),
        .cfg_wdata  (cfg_wdata),
        .take       (take),
        .vector     (vector),
        .cause      (cause),
        .irq_ack    (irq_ack),
        .in_service (in_service),
        .mask       (mask),
        .kerr       (kerr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pend[i] = 1'b0;
            m_mask[i] = 1'b1;
            m_prev[i] = 1'b0;
        end
        m_ack_src = -1;
        m_svc     = 1'b0;
        m_kerr    = 1'b0;
    endtask

    // Winning source: -1 none, 0 illegal opcode, 1+i for interrupt i.
    function automatic int model_winner();
        if (m_svc || monin || !step_en) return -1;
        if (illop) return 0;
        for (int i = 0; i < 3; i++) begin
            if (m_pend[i] && m_mask[i]) return 1 + i;
        end
        return -1;
    endfunction

    task automatic model_compare();
        int w;
        int c;
        int ack;
        w   = model_winner();
        c   = (w < 0) ? 0 : w + 1;
        ack = (m_ack_src < 0) ? 0 : (1 << m_ack_src);
        check("take",       32'(take),       32'(w >= 0));
        check("cause",      32'(cause),      32'(c));
        check("vector",     vector,          32'h8000_0000 + 32'(4 * c));
        check("irq_ack",    32'(irq_ack),    32'(ack));
        check("in_service", 32'(in_service), 32'(m_svc));
        check("mask",       32'(mask),       {29'd0, m_mask[2], m_mask[1], m_mask[0]});
        check("kerr",       32'(kerr),       32'(m_kerr));
    endtask

    task automatic model_edge();
        int w;
        if (reset) begin
            model_reset();
            return;
        end
        w = model_winner();
        m_ack_src = (w >= 1) ? w - 1 : -1;
        for (int i = 0; i < 3; i++) begin
            if (irq_src[i] && !m_prev[i])  m_pend[i] = 1'b1;
            else if (m_ack_src == i)       m_pend[i] = 1'b0;
            m_prev[i] = irq_src[i];
            if (cfg_wr) m_mask[i] = cfg_wdata[i];
        end
        if (illop && monin) m_kerr = 1'b1;
        if (!m_svc && w >= 0)           m_svc = 1'b1;
        else if (m_svc && eret && step_en) m_svc = 1'b0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cyc();
        @(negedge clk);
        model_compare();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        cyc();
        eret = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_src = '0; monin = 1'b0; illop = 1'b0;
        step_en = 1'b1; eret = 1'b0; cfg_wr = 1'b0; cfg_wdata = '0;
        model_reset();
        cyc(); cyc();
        reset = 1'b0;
        #1;
        check("rst take",   32'(take), 32'd0);
        check("rst cause",  32'(cause), 32'd0);
        check("rst vector", vector, 32'h8000_0000);
        check("rst mask",   32'(mask), 32'd7);
        check("rst svc",    32'(in_service), 32'd0);
        check("rst kerr",   32'(kerr), 32'd0);

        // Single timer pulse.
        irq_src = 3'b001; cyc();
        irq_src = 3'b000; #1;
        check("t1 take",   32'(take), 32'd1);
        check("t1 cause",  32'(cause), 32'd2);
        check("t1 vector", vector, 32'h8000_0008);
        cyc();
        check("t1 ack",    32'(irq_ack), 32'b001);
        check("t1 svc",    32'(in_service), 32'd1);
        cyc();
        do_eret();

        // Two simultaneous events: UART TX first, then UART RX.
        irq_src = 3'b110; cyc();
        irq_src = 3'b000; #1;
        check("t2 cause",  32'(cause), 32'd3);
        check("t2 vector", vector, 32'h8000_000C);
        cyc();
        check("t2 ack",    32'(irq_ack), 32'b010);
        cyc();
        do_eret();
        check("t2b take",   32'(take), 32'd1);
        check("t2b cause",  32'(cause), 32'd4);
        check("t2b vector", vector, 32'h8000_0010);
        cyc(); cyc();
        do_eret();

        // Illegal opcode outranks a pending interrupt.
        irq_src = 3'b001; cyc();
        irq_src = 3'b000; illop = 1'b1; #1;
        check("t3 cause",  32'(cause), 32'd1);
        check("t3 vector", vector, 32'h8000_0004);
        cyc();
        illop = 1'b0;
        check("t3 ack",    32'(irq_ack), 32'b000);
        do_eret();
        check("t3 retained", 32'(cause), 32'd2);
        cyc(); cyc();
        do_eret();

        // Kernel mode suppresses traps and flags illegal opcodes.
        irq_src = 3'b100; cyc();
        irq_src = 3'b000; monin = 1'b1; illop = 1'b1; #1;
        check("t4 take", 32'(take), 32'd0);
        cyc();
        check("t4 kerr", 32'(kerr), 32'd1);
        illop = 1'b0; monin = 1'b0; #1;
        check("t4 take2",  32'(take), 32'd1);
        check("t4 cause2", 32'(cause), 32'd4);
        cyc(); cyc();
        do_eret();

        // Mask holds the event until it is unmasked.
        cfg_wr = 1'b1; cfg_wdata = 3'b000; cyc();
        cfg_wr = 1'b0;
        check("t5 mask", 32'(mask), 32'd0);
        irq_src = 3'b001; cyc();
        irq_src = 3'b000; #1;
        check("t5 masked", 32'(take), 32'd0);
        cyc();
        cfg_wr = 1'b1; cfg_wdata = 3'b001; #1;
        check("t5 old mask", 32'(take), 32'd0);
        cyc();
        cfg_wr = 1'b0; #1;
        check("t5 unmask take", 32'(take), 32'd1);
        check("t5 cause",       32'(cause), 32'd2);
        cyc();

        // Reset while in service with a held event.
        irq_src = 3'b100; cyc();
        irq_src = 3'b000; cyc();
        check("t6 svc before", 32'(in_service), 32'd1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("t6 svc",  32'(in_service), 32'd0);
        check("t6 mask", 32'(mask), 32'd7);
        check("t6 ack",  32'(irq_ack), 32'd0);
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t6 no take", 32'(take), 32'd0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
